// File: rtl/instr_mem_pkg.sv
// Shared definitions for the instruction store path: default placement of the
// image and the loader state encoding, reused by the store and fetch logic.
package instr_mem_pkg;

    localparam logic [31:0] DEF_BASE_ADDR   = 32'h0040_0000;
    localparam int unsigned DEF_DEPTH_WORDS = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        WRITE  = 2'd2,
        FINISH = 2'd3
    } loader_state_t;

endpackage

// File: rtl/byte_assembler.sv
// Big-endian byte-to-word shift register with a 2-bit byte index.
// full flags the cycle in which the fourth byte of a word is being accepted.
module byte_assembler (
    input  logic        clock,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  in_byte,
    output logic [31:0] word,
    output logic        full
);

    logic [1:0] idx;

    always_ff @(posedge clock) begin
        if (clear) begin
            word <= '0;
            idx  <= '0;
        end else if (shift_en) begin
            word <= {word[23:0], in_byte};
            idx  <= idx + 2'd1;
        end
    end

    assign full = shift_en && (idx == 2'd3);

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a big-endian byte stream into the instruction store one 32-bit word
// at a time, starting at BASE_ADDR.
//
// state  | meaning
// IDLE   | waiting for start after clear
// LOAD   | accepting image bytes, in_ready=1
// WRITE  | one-cycle write strobe of the assembled word
// FINISH | session over, done=1 (err=1 if request exceeded capacity)
module instr_mem_loader
    import instr_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [8:0]  num_words,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [8:0]  word_count
);

    loader_state_t state, state_nx;
    logic [8:0]    count, count_nx;
    logic [8:0]    num_q, num_nx;
    logic          err_q, err_nx;
    logic          restart;
    logic          shift_en;
    logic          full;
    logic [31:0]   word;

    always_ff @(posedge clock) begin
        if (clear) begin
            state <= IDLE;
            count <= '0;
            num_q <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            count <= count_nx;
            num_q <= num_nx;
            err_q <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        count_nx = count;
        num_nx   = num_q;
        err_nx   = err_q;
        restart  = 1'b0;
        case (state)
            IDLE, FINISH: begin
                if (start) begin
                    restart  = 1'b1;
                    count_nx = '0;
                    err_nx   = 1'b0;
                    num_nx   = num_words;
                    if (num_words == 9'd0) begin
                        state_nx = FINISH;
                    end else if (32'(num_words) > DEPTH_WORDS) begin
                        state_nx = FINISH;
                        err_nx   = 1'b1;
                    end else begin
                        state_nx = LOAD;
                    end
                end
            end
            LOAD: begin
                if (full) state_nx = WRITE;
            end
            WRITE: begin
                count_nx = count + 9'd1;
                state_nx = (count + 9'd1 == num_q) ? FINISH : LOAD;
            end
            default: state_nx = IDLE;
        endcase
    end

    // A fresh session must not inherit partial bytes from an aborted one.
    byte_assembler u_asm (
        .clock    (clock),
        .clear    (clear | restart),
        .shift_en (shift_en),
        .in_byte  (in_byte),
        .word     (word),
        .full     (full)
    );

    assign in_ready   = (state == LOAD);
    assign shift_en   = in_valid && in_ready;
    assign wr_en      = (state == WRITE);
    assign wr_addr    = wr_en ? (BASE_ADDR + {21'd0, count, 2'b00}) : 32'd0;
    assign wr_data    = wr_en ? word : 32'd0;
    assign busy       = (state == LOAD) || (state == WRITE);
    assign done       = (state == FINISH);
    assign err        = err_q;
    assign word_count = count;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: hand-computed writes, timing and
// status for normal, stalled, empty, oversize, busy-restart and aborted loads.
module tb_instr_mem_loader;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  num_words = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = '0;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [8:0]  word_count;

    int total = 0;
    int bad   = 0;
    int ncyc  = 0;
    int zviol = 0;
    int s1, s2;
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    int          wc[$];

    instr_mem_loader dut (
        .clock      (clock),
        .clear      (clear),
        .start      (start),
        .num_words  (num_words),
        .in_valid   (in_valid),
        .in_byte    (in_byte),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        ncyc++;
        if (wr_en) begin
            wa.push_back(wr_addr);
            wd.push_back(wr_data);
            wc.push_back(ncyc);
        end else if (wr_addr != 32'd0 || wr_data != 32'd0) begin
            zviol++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input logic [8:0] n);
        start     = 1'b1;
        num_words = n;
        tick();
        start     = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_byte  = b;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("send_timeout", 32'd1, 32'd0);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) chk("done_timeout", 32'd1, 32'd0);
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wc.delete();
    endtask

    initial begin
        // reset
        clear = 1'b1;
        tick();
        tick();
        clear = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        chk("rst_wr_addr", wr_addr, 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);

        // three words back-to-back
        clear_log();
        do_start(9'd3);
        s1 = ncyc;
        chk("s1_busy", 32'(busy), 32'd1);
        chk("s1_in_ready", 32'(in_ready), 32'd1);
        send_word(32'h2200_0001);
        send_word(32'h2210_8000);
        send_word(32'h2210_0001);
        wait_done();
        chk("s1_nwrites", wa.size(), 32'd3);
        if (wa.size() == 3) begin
            chk("s1_a0", wa[0], 32'h0040_0000);
            chk("s1_d0", wd[0], 32'h2200_0001);
            chk("s1_a1", wa[1], 32'h0040_0004);
            chk("s1_d1", wd[1], 32'h2210_8000);
            chk("s1_a2", wa[2], 32'h0040_0008);
            chk("s1_d2", wd[2], 32'h2210_0001);
            chk("s1_first_delay", 32'(wc[0] - s1), 32'd5);
            chk("s1_word_period", 32'(wc[1] - wc[0]), 32'd5);
        end
        chk("s1_done", 32'(done), 32'd1);
        chk("s1_err", 32'(err), 32'd0);
        chk("s1_busy_end", 32'(busy), 32'd0);
        chk("s1_word_count", 32'(word_count), 32'd3);

        // same stream with a 7-cycle gap after byte 2
        clear_log();
        do_start(9'd3);
        s2 = ncyc;
        send_byte(8'h22);
        send_byte(8'h00);
        repeat (7) tick();
        send_byte(8'h00);
        send_byte(8'h01);
        send_word(32'h2210_8000);
        send_word(32'h2210_0001);
        wait_done();
        chk("s2_nwrites", wa.size(), 32'd3);
        if (wa.size() == 3) begin
            chk("s2_d0", wd[0], 32'h2200_0001);
            chk("s2_a2", wa[2], 32'h0040_0008);
            chk("s2_d2", wd[2], 32'h2210_0001);
            chk("s2_first_delay", 32'(wc[0] - s2), 32'd12);
        end
        chk("s2_word_count", 32'(word_count), 32'd3);

        // zero-length and oversize requests
        clear_log();
        do_start(9'd0);
        chk("z_done", 32'(done), 32'd1);
        chk("z_err", 32'(err), 32'd0);
        chk("z_word_count", 32'(word_count), 32'd0);
        tick();
        chk("z_nwrites", wa.size(), 32'd0);
        do_start(9'd257);
        chk("ov_done", 32'(done), 32'd1);
        chk("ov_err", 32'(err), 32'd1);
        chk("ov_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_byte  = 8'hAA;
        tick();
        tick();
        in_valid = 1'b0;
        chk("ov_in_ready_hold", 32'(in_ready), 32'd0);
        chk("ov_busy", 32'(busy), 32'd0);
        chk("ov_nwrites", wa.size(), 32'd0);

        // restart request while busy is ignored
        clear_log();
        do_start(9'd2);
        chk("bs_err_cleared", 32'(err), 32'd0);
        send_word(32'h1122_3344);
        tick();
        do_start(9'd1);
        send_word(32'h5566_7788);
        wait_done();
        chk("bs_nwrites", wa.size(), 32'd2);
        if (wa.size() == 2) begin
            chk("bs_a1", wa[1], 32'h0040_0004);
            chk("bs_d1", wd[1], 32'h5566_7788);
        end
        chk("bs_word_count", 32'(word_count), 32'd2);

        // clear mid-session, then a fresh one-word load
        clear_log();
        do_start(9'd3);
        send_word(32'hA1A2_A3A4);
        send_byte(8'hB1);
        send_byte(8'hB2);
        clear = 1'b1;
        in_valid = 1'b1;
        in_byte = 8'hB3;
        start = 1'b1;
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        start = 1'b0;
        chk("cl_nwrites", wa.size(), 32'd1);
        chk("cl_busy", 32'(busy), 32'd0);
        chk("cl_in_ready", 32'(in_ready), 32'd0);
        chk("cl_done", 32'(done), 32'd0);
        chk("cl_word_count", 32'(word_count), 32'd0);
        chk("cl_wr_en", 32'(wr_en), 32'd0);
        clear_log();
        do_start(9'd1);
        send_word(32'hDEAD_BEEF);
        wait_done();
        chk("cl_new_nwrites", wa.size(), 32'd1);
        if (wa.size() == 1) begin
            chk("cl_new_a0", wa[0], 32'h0040_0000);
            chk("cl_new_d0", wd[0], 32'hDEAD_BEEF);
        end
        chk("cl_new_word_count", 32'(word_count), 32'd1);

        // full-depth load with incrementing byte pattern
        clear_log();
        do_start(9'd256);
        for (int i = 0; i < 1024; i++) send_byte(8'(i));
        wait_done();
        chk("full_nwrites", wa.size(), 32'd256);
        if (wa.size() == 256) begin
            chk("full_a0", wa[0], 32'h0040_0000);
            chk("full_d0", wd[0], 32'h0001_0203);
            chk("full_a_last", wa[255], 32'h0040_03FC);
            chk("full_d_last", wd[255], 32'hFCFD_FEFF);
        end
        chk("full_done", 32'(done), 32'd1);
        chk("full_err", 32'(err), 32'd0);
        chk("full_word_count", 32'(word_count), 32'd256);

        chk("idle_bus_zero", 32'(zviol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
